// File: rtl/enigma_arb_if.sv
// enigma_arb_if: bundles the A/B request ports, the C output port with its
// conflict/release side-band, and the outstanding-count output of enigma_arb.
//   slave  : arbiter side (consumes A/B, drives C)
//   master : environment side (drives A/B, consumes C)
interface enigma_arb_if #(
    parameter int PW = 128,
    parameter int IW = 5,
    parameter int QW = 2
);
    logic [PW-1:0] payload_a;
    logic [IW-1:0] id_a;
    logic [QW-1:0] qos_a;
    logic          valid_a;
    logic          ready_a;

    logic [PW-1:0] payload_b;
    logic [IW-1:0] id_b;
    logic [QW-1:0] qos_b;
    logic          valid_b;
    logic          ready_b;

    logic [PW-1:0] payload_c;
    logic [IW:0]   id_c;
    logic [QW-1:0] qos_c;
    logic          valid_c;
    logic          ready_c;
    logic          conflict_c;
    logic          release_c;
    logic [IW:0]   releaseid_c;
    logic [IW+1:0] outstanding;

    modport slave (
        input  payload_a, id_a, qos_a, valid_a,
        output ready_a,
        input  payload_b, id_b, qos_b, valid_b,
        output ready_b,
        output payload_c, id_c, qos_c, valid_c,
        input  ready_c, conflict_c, release_c, releaseid_c,
        output outstanding
    );

    modport master (
        output payload_a, id_a, qos_a, valid_a,
        input  ready_a,
        output payload_b, id_b, qos_b, valid_b,
        input  ready_b,
        input  payload_c, id_c, qos_c, valid_c,
        output ready_c, conflict_c, release_c, releaseid_c,
        input  outstanding
    );
endinterface

// File: rtl/enigma_arb.sv
// enigma_arb: QoS-aware 2:1 arbiter merging ports A and B onto port C.
//   - id_c = {src, id}, src 0 = A, 1 = B.
//   - Scoreboard of 2^(IW+1) outstanding IDs; a request whose tagged ID is
//     still outstanding is not eligible.
//   - One output register, EMPTY/FULL/CHECK FSM; the beat is held through
//     CHECK so a conflict_c can replay it.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   io       : enigma_arb_if.slave (A/B requests, C output, release side-band,
//              outstanding popcount)
// Optional feature: define ENIGMA_ARB_AGING_EN to add per-port 4-bit wait
// counters that override QoS once they reach AGE_MAX.
module enigma_arb #(
    parameter int PW      = 128,
    parameter int IW      = 5,
    parameter int QW      = 2,
    parameter int AGE_MAX = 15
) (
    input  logic         clk,
    input  logic         rst,
    enigma_arb_if.slave  io
);
    localparam int SBW = 1 << (IW + 1);

    // A 4-bit saturating counter can never exceed 15.
    if (AGE_MAX < 1 || AGE_MAX > 15) begin : g_bad_age_max
        $error("enigma_arb: AGE_MAX must be in 1..15");
    end

    typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_CHECK} state_t;

    state_t        state_q, state_d;
    logic [SBW-1:0] sb_q, sb_d;
    logic [IW+1:0] outst_q, outst_d;
    logic          rr_q, rr_d;          // 0: A wins a tie, 1: B wins a tie
    logic [PW-1:0] pl_q, pl_d;
    logic [IW:0]   id_q, id_d;
    logic [QW-1:0] qos_q, qos_d;

    logic elig_a, elig_b;
    logic hit_a, hit_b;
    logic pick_a, pick_b;
    logic can_load, grant_a, grant_b, load;

    // Eligibility uses the scoreboard before this cycle's set/clear.
    assign elig_a = io.valid_a && !sb_q[{1'b0, io.id_a}];
    assign elig_b = io.valid_b && !sb_q[{1'b1, io.id_b}];

`ifdef ENIGMA_ARB_AGING_EN
    localparam logic [3:0] AGE_TH = 4'(AGE_MAX);
    logic [3:0] age_a_q, age_b_q;

    // Count cycles spent eligible but not granted; saturate so the override
    // cannot wrap away before the port finally gets a load slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            age_a_q <= '0;
            age_b_q <= '0;
        end else begin
            if (!elig_a || grant_a)    age_a_q <= '0;
            else if (age_a_q != 4'hF)  age_a_q <= age_a_q + 4'd1;
            if (!elig_b || grant_b)    age_b_q <= '0;
            else if (age_b_q != 4'hF)  age_b_q <= age_b_q + 4'd1;
        end
    end

    assign hit_a = age_a_q >= AGE_TH;
    assign hit_b = age_b_q >= AGE_TH;
`else
    assign hit_a = 1'b0;
    assign hit_b = 1'b0;
`endif

    always_comb begin
        pick_a = 1'b0;
        pick_b = 1'b0;
        if (elig_a && elig_b) begin
            if (hit_a && hit_b)               pick_b = rr_q;
            else if (hit_a)                   pick_b = 1'b0;
            else if (hit_b)                   pick_b = 1'b1;
            else if (io.qos_a > io.qos_b)     pick_b = 1'b0;
            else if (io.qos_a < io.qos_b)     pick_b = 1'b1;
            else                              pick_b = rr_q;
            pick_a = !pick_b;
        end else begin
            pick_a = elig_a;
            pick_b = elig_b;
        end
    end

    // A replay in CHECK takes the slot, so no new beat loads that cycle.
    assign can_load = !rst && ((state_q == ST_EMPTY) ||
                               (state_q == ST_CHECK && !io.conflict_c));
    assign grant_a  = can_load && pick_a;
    assign grant_b  = can_load && pick_b;
    assign load     = grant_a || grant_b;

    always_comb begin
        state_d = state_q;
        pl_d    = pl_q;
        id_d    = id_q;
        qos_d   = qos_q;
        rr_d    = rr_q;
        case (state_q)
            ST_EMPTY: if (load) state_d = ST_FULL;
            ST_FULL:  if (io.ready_c) state_d = ST_CHECK;
            ST_CHECK: begin
                if (io.conflict_c) state_d = ST_FULL;
                else if (load)     state_d = ST_FULL;
                else               state_d = ST_EMPTY;
            end
            default:  state_d = ST_EMPTY;
        endcase
        if (load) begin
            pl_d  = grant_a ? io.payload_a : io.payload_b;
            id_d  = grant_a ? {1'b0, io.id_a} : {1'b1, io.id_b};
            qos_d = grant_a ? io.qos_a : io.qos_b;
            rr_d  = grant_a;   // point at the other port
        end
    end

    // Scoreboard: set on C handshake, clear on release; clear applied last so
    // it wins on a same-index collision.
    always_comb begin
        sb_d = sb_q;
        if (state_q == ST_FULL && io.ready_c) sb_d[id_q] = 1'b1;
        if (io.release_c)                     sb_d[io.releaseid_c] = 1'b0;
        outst_d = '0;
        for (int i = 0; i < SBW; i++) outst_d = outst_d + {{(IW+1){1'b0}}, sb_d[i]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            sb_q    <= '0;
            outst_q <= '0;
            rr_q    <= 1'b0;
            pl_q    <= '0;
            id_q    <= '0;
            qos_q   <= '0;
        end else begin
            state_q <= state_d;
            sb_q    <= sb_d;
            outst_q <= outst_d;
            rr_q    <= rr_d;
            pl_q    <= pl_d;
            id_q    <= id_d;
            qos_q   <= qos_d;
        end
    end

    assign io.ready_a     = grant_a;
    assign io.ready_b     = grant_b;
    assign io.valid_c     = (state_q == ST_FULL);
    assign io.payload_c   = pl_q;
    assign io.id_c        = id_q;
    assign io.qos_c       = qos_q;
    assign io.outstanding = outst_q;
endmodule

// File: tb/tb_enigma_arb.sv
module tb_enigma_arb;
    localparam int PW = 128;
    localparam int IW = 5;
    localparam int QW = 2;
`ifdef ENIGMA_ARB_AGING_EN
    localparam bit AGING = 1'b1;
`else
    localparam bit AGING = 1'b0;
`endif

    typedef logic [PW+IW+1+QW-1:0] beat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    enigma_arb_if #(.PW(PW), .IW(IW), .QW(QW)) bus ();

    enigma_arb #(.PW(PW), .IW(IW), .QW(QW), .AGE_MAX(15)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    beat_t exp_q[$];
    beat_t mon_e;
    int    n_chk  = 0;
    int    n_fail = 0;

    task automatic chk(string tag, logic [135:0] obs, logic [135:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] pl(int n);
        return {4{32'(n) ^ 32'hA5A5_0000}};
    endfunction

    task automatic push(logic src, logic [IW-1:0] id, logic [QW-1:0] q, logic [PW-1:0] p);
        exp_q.push_back({p, src, id, q});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Every C handshake must match the next expected beat.
    always @(negedge clk) begin
        if (!rst && bus.valid_c && bus.ready_c) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $error("FAIL c_beat_unexpected: observed id_c %0h expected no beat", bus.id_c);
            end else begin
                mon_e = exp_q.pop_front();
                chk("c_beat", 136'({bus.payload_c, bus.id_c, bus.qos_c}), 136'(mon_e));
            end
        end
    end

    initial begin
        int ia, ib;
        logic ea, eb;

        rst = 1'b1;
        bus.payload_a = '0; bus.id_a = '0; bus.qos_a = '0; bus.valid_a = 1'b1;
        bus.payload_b = '0; bus.id_b = '0; bus.qos_b = '0; bus.valid_b = 1'b0;
        bus.ready_c = 1'b0; bus.conflict_c = 1'b0;
        bus.release_c = 1'b0; bus.releaseid_c = '0;

        // Reset state
        #2;
        chk("rst_ready_a", 136'(bus.ready_a), 136'(1'b0));
        chk("rst_valid_c", 136'(bus.valid_c), 136'(1'b0));
        chk("rst_outstanding", 136'(bus.outstanding), 136'(0));
        chk("rst_c_fields", 136'({bus.payload_c, bus.id_c, bus.qos_c}), 136'(0));
        bus.valid_a = 1'b0;
        step();
        rst = 1'b0;

        // T1: QoS ordering, B (qos 2) before A (qos 1)
        bus.payload_a = pl(1); bus.id_a = 5'd3; bus.qos_a = 2'd1; bus.valid_a = 1'b1;
        bus.payload_b = pl(2); bus.id_b = 5'd3; bus.qos_b = 2'd2; bus.valid_b = 1'b1;
        bus.ready_c = 1'b1;
        #1;
        chk("t1_ready_ab", 136'({bus.ready_a, bus.ready_b}), 136'(2'b01));
        push(1'b1, 5'd3, 2'd2, pl(2));
        step(); bus.valid_b = 1'b0; #1;
        chk("t1_full_valid_c", 136'(bus.valid_c), 136'(1'b1));
        chk("t1_full_id_c", 136'(bus.id_c), 136'(6'h23));
        chk("t1_full_ready_a", 136'(bus.ready_a), 136'(1'b0));
        step(); #1;
        chk("t1_check_ready_a", 136'(bus.ready_a), 136'(1'b1));
        chk("t1_outstanding1", 136'(bus.outstanding), 136'(1));
        push(1'b0, 5'd3, 2'd1, pl(1));
        step(); bus.valid_a = 1'b0; #1;
        chk("t1_a_id_c", 136'(bus.id_c), 136'(6'h03));
        step(); #1;
        chk("t1_outstanding2", 136'(bus.outstanding), 136'(2));
        bus.release_c = 1'b1; bus.releaseid_c = 6'h23;
        step(); bus.releaseid_c = 6'h03;
        step(); bus.release_c = 1'b0; #1;
        chk("t1_released", 136'(bus.outstanding), 136'(0));

        // T2: equal QoS round-robin from A after reset
        rst = 1'b1; #1;
        step(); rst = 1'b0;
        ia = 0; ib = 0;
        bus.qos_a = 2'd0; bus.id_a = 5'd0; bus.payload_a = pl(10); bus.valid_a = 1'b1;
        bus.qos_b = 2'd0; bus.id_b = 5'd0; bus.payload_b = pl(20); bus.valid_b = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (k % 2 == 0) begin
                chk("t2_grant_a", 136'({bus.ready_a, bus.ready_b}), 136'(2'b10));
                push(1'b0, 5'(ia), 2'd0, pl(10 + ia));
                ia++;
            end else begin
                chk("t2_grant_b", 136'({bus.ready_a, bus.ready_b}), 136'(2'b01));
                push(1'b1, 5'(ib), 2'd0, pl(20 + ib));
                ib++;
            end
            step();
            bus.id_a = 5'(ia); bus.payload_a = pl(10 + ia);
            bus.id_b = 5'(ib); bus.payload_b = pl(20 + ib);
            if (k == 3) begin bus.valid_a = 1'b0; bus.valid_b = 1'b0; end
            #1;
            chk("t2_full_no_grant", 136'({bus.ready_a, bus.ready_b}), 136'(2'b00));
            step();
        end
        #1;
        chk("t2_outstanding4", 136'(bus.outstanding), 136'(4));
        bus.release_c = 1'b1;
        bus.releaseid_c = 6'h00; step();
        bus.releaseid_c = 6'h20; step();
        bus.releaseid_c = 6'h01; step();
        bus.releaseid_c = 6'h21; step();
        bus.release_c = 1'b0; #1;
        chk("t2_released", 136'(bus.outstanding), 136'(0));

        // T3: outstanding ID blocks a repeat until released
        bus.id_a = 5'd5; bus.qos_a = 2'd1; bus.payload_a = pl(30); bus.valid_a = 1'b1;
        #1;
        chk("t3_first_grant", 136'(bus.ready_a), 136'(1'b1));
        push(1'b0, 5'd5, 2'd1, pl(30));
        step(); bus.payload_a = pl(31); #1;
        chk("t3_full_ready_a", 136'(bus.ready_a), 136'(1'b0));
        step(); #1;
        chk("t3_blocked_check", 136'(bus.ready_a), 136'(1'b0));
        step(); #1;
        chk("t3_blocked_empty", 136'(bus.ready_a), 136'(1'b0));
        bus.release_c = 1'b1; bus.releaseid_c = 6'h05; #1;
        chk("t3_blocked_release_cycle", 136'(bus.ready_a), 136'(1'b0));
        step(); bus.release_c = 1'b0; #1;
        chk("t3_unblocked", 136'(bus.ready_a), 136'(1'b1));
        push(1'b0, 5'd5, 2'd1, pl(31));
        step(); bus.valid_a = 1'b0;
        step();
        bus.release_c = 1'b1; bus.releaseid_c = 6'h05;
        step(); bus.release_c = 1'b0; #1;
        chk("t3_released", 136'(bus.outstanding), 136'(0));

        // T4: conflict replays the held beat, scoreboard count unchanged
        bus.id_a = 5'h11; bus.qos_a = 2'd2; bus.payload_a = pl(40); bus.valid_a = 1'b1;
        #1;
        chk("t4_grant", 136'(bus.ready_a), 136'(1'b1));
        push(1'b0, 5'h11, 2'd2, pl(40));
        step(); bus.id_a = 5'h12; bus.payload_a = pl(41);
        step(); bus.conflict_c = 1'b1; #1;
        chk("t4_conflict_no_grant", 136'(bus.ready_a), 136'(1'b0));
        chk("t4_outstanding_before", 136'(bus.outstanding), 136'(1));
        push(1'b0, 5'h11, 2'd2, pl(40));
        step(); bus.conflict_c = 1'b0; bus.valid_a = 1'b0; #1;
        chk("t4_replay_valid", 136'(bus.valid_c), 136'(1'b1));
        chk("t4_replay_id", 136'(bus.id_c), 136'(6'h11));
        step(); #1;
        chk("t4_outstanding_after", 136'(bus.outstanding), 136'(1));
        bus.release_c = 1'b1; bus.releaseid_c = 6'h11;
        step(); bus.release_c = 1'b0; #1;
        chk("t4_released", 136'(bus.outstanding), 136'(0));

        // T5: back-pressure holds the C fields and blocks grants
        bus.ready_c = 1'b0;
        bus.id_b = 5'd2; bus.qos_b = 2'd3; bus.payload_b = pl(50); bus.valid_b = 1'b1;
        bus.id_a = 5'd7; bus.qos_a = 2'd0; bus.payload_a = pl(51); bus.valid_a = 1'b1;
        #1;
        chk("t5_grant_b", 136'({bus.ready_a, bus.ready_b}), 136'(2'b01));
        push(1'b1, 5'd2, 2'd3, pl(50));
        step(); bus.id_b = 5'd3; bus.payload_b = pl(52);
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("t5_stall_fields", 136'({bus.payload_c, bus.id_c, bus.qos_c}),
                136'({pl(50), 6'h22, 2'd3}));
            chk("t5_stall_ready", 136'({bus.ready_a, bus.ready_b, bus.valid_c}), 136'(3'b001));
            step();
        end
        bus.ready_c = 1'b1; bus.valid_a = 1'b0; bus.valid_b = 1'b0;
        step();
        bus.release_c = 1'b1; bus.releaseid_c = 6'h22;
        step(); bus.release_c = 1'b0; #1;
        chk("t5_released", 136'(bus.outstanding), 136'(0));

        // T6: high-QoS B saturates; A only wins through aging
        ib = 10;
        bus.id_a = 5'd20; bus.qos_a = 2'd0; bus.payload_a = pl(60); bus.valid_a = 1'b1;
        bus.id_b = 5'(ib); bus.qos_b = 2'd3; bus.payload_b = pl(70 + ib); bus.valid_b = 1'b1;
        for (int t = 0; t < 20; t++) begin
            #1;
            ea = AGING && (t == 16);
            eb = (t % 2 == 0) && !ea;
            chk("t6_grant", 136'({bus.ready_a, bus.ready_b}), 136'({ea, eb}));
            if (eb) push(1'b1, 5'(ib), 2'd3, pl(70 + ib));
            if (ea) push(1'b0, 5'd20, 2'd0, pl(60));
            step();
            if (eb) begin
                ib++;
                bus.id_b = 5'(ib); bus.payload_b = pl(70 + ib);
            end
            if (ea) bus.valid_a = 1'b0;
            if (t == 19) begin bus.valid_a = 1'b0; bus.valid_b = 1'b0; end
        end
        step();
        bus.release_c = 1'b1;
        for (int i = 10; i < ib; i++) begin
            bus.releaseid_c = {1'b1, 5'(i)};
            step();
        end
        if (AGING) begin
            bus.releaseid_c = 6'h14;
            step();
        end
        bus.release_c = 1'b0; #1;
        chk("t6_released", 136'(bus.outstanding), 136'(0));

        step(); step();
        chk("queue_drained", 136'(exp_q.size()), 136'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
